// File: rtl/rom_reader.sv
// Burst reader for a one-cycle-latency ROM. Sequential reads are buffered in a
// 4-entry FIFO and delivered as a valid/ready stream with a last-word marker.
module rom_reader #(
   parameter int unsigned AddrWidth = 8,
   parameter int unsigned DataWidth = 16,
   parameter int unsigned LenWidth  = AddrWidth + 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [AddrWidth-1:0] start_addr,
   input  logic [LenWidth-1:0]  length,
   output logic                 busy,
   output logic                 done,
   output logic [AddrWidth-1:0] rom_addr,
   output logic                 rom_read_req,
   input  logic [DataWidth-1:0] rom_read_data,
   input  logic                 rom_read_data_valid,
   output logic [DataWidth-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last
);

   localparam int unsigned Depth    = 4;
   localparam int unsigned PtrWidth = 2;
   localparam int unsigned CntWidth = 3;
   localparam int unsigned OccWidth = CntWidth + 1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t               state;
   logic [AddrWidth-1:0] addr_cnt;
   logic [LenWidth-1:0]  issue_rem;
   logic [LenWidth-1:0]  deliver_rem;
   logic [CntWidth-1:0]  inflight;
   logic [CntWidth-1:0]  count;
   logic [PtrWidth-1:0]  head;
   logic [PtrWidth-1:0]  tail;
   logic [DataWidth-1:0] mem [Depth];

   logic                 pop;
   logic                 push;
   logic                 issue;
   logic                 launch;
   logic [OccWidth-1:0]  occupancy;

   // Credit check counts a same-cycle pop, so issue resumes right after a pop.
   always_comb begin
      pop       = (count != '0) && out_ready;
      push      = rom_read_data_valid && (inflight != '0);
      occupancy = OccWidth'(count) + OccWidth'(inflight) - OccWidth'(pop);
      issue     = (state == S_RUN) && (issue_rem != '0) &&
                  (occupancy < OccWidth'(Depth));
      launch    = (state == S_IDLE) && start && (length != '0);
   end

   assign out_valid = (count != '0);
   assign out_data  = mem[head];
   assign out_last  = out_valid && (deliver_rem == LenWidth'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         rom_read_req <= 1'b0;
         rom_addr     <= '0;
         addr_cnt     <= '0;
         issue_rem    <= '0;
         deliver_rem  <= '0;
         inflight     <= '0;
         count        <= '0;
         head         <= '0;
         tail         <= '0;
         mem          <= '{default: '0};
      end else begin
         done         <= 1'b0;
         rom_read_req <= 1'b0;

         if (push) begin
            mem[tail] <= rom_read_data;
            tail      <= tail + PtrWidth'(1);
         end
         if (pop) begin
            head <= head + PtrWidth'(1);
         end
         count    <= count + CntWidth'(push) - CntWidth'(pop);
         inflight <= inflight + CntWidth'(issue || launch) - CntWidth'(push);

         case (state)
            S_IDLE: begin
               // The first request goes out on the command edge itself.
               if (start) begin
                  if (length == '0) begin
                     done <= 1'b1;
                  end else begin
                     state        <= S_RUN;
                     busy         <= 1'b1;
                     rom_read_req <= 1'b1;
                     rom_addr     <= start_addr;
                     addr_cnt     <= start_addr + AddrWidth'(1);
                     issue_rem    <= length - LenWidth'(1);
                     deliver_rem  <= length;
                  end
               end
            end
            S_RUN: begin
               if (issue) begin
                  rom_read_req <= 1'b1;
                  rom_addr     <= addr_cnt;
                  addr_cnt     <= addr_cnt + AddrWidth'(1);
                  issue_rem    <= issue_rem - LenWidth'(1);
               end
               if (pop) begin
                  deliver_rem <= deliver_rem - LenWidth'(1);
                  if (deliver_rem == LenWidth'(1)) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/rom_reader.md
# rom_reader

Initiator side of the ROM read interface. `rom_reader` accepts a burst command (start address, word count) and issues sequential reads on the `read_req`/`addr` → `read_data`/`read_data_valid` interface, which has a fixed one-cycle read latency. It buffers returned words in a 4-entry FIFO and presents them as a valid/ready stream with a last-word marker. It sits between any ROM instance and a consumer such as a loader, sequencer or table walker.

## Interface
- `AddrWidth`, 8: ROM address width.
- `DataWidth`, 16: ROM word width.
- `LenWidth`, `AddrWidth+1`: width of the burst length field, so a full-ROM burst is expressible.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset; asynchronous assert, active-low. One clock, reset asynchronous and active-low.
- `start`  in  1  burst command strobe, sampled only when `busy`=0.
- `start_addr`  in  AddrWidth  first ROM address of the burst.
- `length`  in  LenWidth  number of words in the burst.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse at burst completion.
- `rom_addr`  out  AddrWidth  read address to the ROM.
- `rom_read_req`  out  1  read request to the ROM.
- `rom_read_data`  in  DataWidth  ROM read data.
- `rom_read_data_valid`  in  1  ROM read data qualifier, one cycle after the request.
- `out_data`  out  DataWidth  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready from the consumer.
- `out_last`  out  1  marks the final word of the burst.

## Operation
- State machine: IDLE → RUN → IDLE.
- IDLE: when `start`=1, latch `start_addr` into the address counter and `length` into two counters:
  - issue-remaining counter;
  - deliver-remaining counter.
- `length`=0 is a special case: no reads are issued, `busy` stays 0, and `done` pulses in the next cycle.
- Any other `length` moves the state to RUN and sets `busy`=1.
- RUN, issue rule: a request is issued when both hold:
  - issue-remaining > 0;
  - FIFO count + in-flight count < 4, where in-flight counts requests not yet written into the FIFO (0–2).
- Issuing a request:
  - registers `rom_read_req`=1 and `rom_addr` for exactly one cycle;
  - increments the address, wrapping modulo 2^AddrWidth (0xFF+1 → 0x00);
  - decrements issue-remaining.
- A response (`rom_read_data_valid`=1 with in-flight > 0) writes `rom_read_data` into the FIFO tail. A response with in-flight = 0 is ignored.
- FIFO: 4 entries, registered. A simultaneous push and pop in one cycle is legal and leaves the count unchanged.
- Stream outputs:
  - `out_valid` = FIFO non-empty; `out_data` = FIFO head.
  - A handshake (`out_valid`&&`out_ready`) pops the head and decrements deliver-remaining.
  - `out_last` = `out_valid` && deliver-remaining == 1.
- Completion: the handshake that pops the last word moves the state to IDLE. In the following cycle `done`=1 for one cycle and `busy`=0.
- `start` while `busy`=1 is ignored, with no effect on the counters.
- Reset mid-burst:
  - all counters, the FIFO and the state clear immediately;
  - a ROM response returning after reset release is ignored, because in-flight = 0.

## Timing
- Reset values: `busy`=0, `done`=0, `rom_read_req`=0, `rom_addr`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
- `start` sampled at edge E0 → first `rom_read_req` in cycle 1 → ROM data valid in cycle 2 → FIFO write at E2 → `out_valid` in cycle 3.
- First-word latency is therefore 3 cycles.
- With `out_ready` held at 1, throughput is 1 word/cycle. Requests occupy consecutive cycles 1..N and stream words occupy cycles 3..N+2.
- Under backpressure, at most 4 words are buffered or in flight. Issue resumes in the cycle after a pop frees a credit.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` are held stable.
- `done` is asserted in the cycle after the final handshake. `busy` falls in that same cycle. A new `start` is accepted in that same cycle.

## Test plan
- Reset check: assert `reset_n`=0 mid-run → all outputs at their reset values in the same cycle, without waiting for a clock edge.
- Basic burst: `start_addr`=0x10, `length`=4, `out_ready`=1 → `rom_addr` 0x10..0x13 in cycles 1–4; `out_valid` in cycles 3–6 carrying ROM words 0x10..0x13; `out_last` in cycle 6; `done` in cycle 7.
- Backpressure: `length`=8, `out_ready`=0 → exactly 4 requests issued, then none. Raise `out_ready` at cycle 10 → all 8 words delivered in order, none lost or duplicated, `done` once.
- Wrap: `start_addr`=0xFE, `length`=3 → addresses 0xFE, 0xFF, 0x00 requested; 3 words delivered.
- Edge commands:
  - `length`=0 → `done` in cycle 1, no `rom_read_req`, `busy` stays 0;
  - a second `start` during a burst → ignored, burst length unchanged.
- Reset mid-burst: `length`=6, `reset_n` low in cycle 4, released in cycle 6 → no stale words appear, no `done` is produced; a subsequent burst with `length`=2 completes normally.
